// File: rtl/dm_responder.sv
// dm_responder: wait-stated req/ready data store with word/byte access; define DM_WRITE_LOG_EN to log committed stores
module dm_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, byte_q, cur_we, cur_byte, in_range;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d, cur_addr, rword, wword;
  logic [7:0] rbyte;
  logic [31:0] mem_q [DEPTH_WORDS];
`ifdef DM_WRITE_LOG_EN
  logic [31:0] pc_q;
  always_ff @(posedge clk)
    if (state_q == IDLE && req) pc_q <= pc;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif
  // In IDLE the load result is formed from the live inputs so a zero-wait response is ready next cycle
  always_comb begin
    cur_addr = state_q == IDLE ? addr : addr_q;
    cur_we = state_q == IDLE ? we : we_q;
    cur_byte = state_q == IDLE ? byte_op : byte_q;
    in_range = cur_addr[31:12] == '0;
    rword = mem_q[cur_addr[AW+1:2]];
    rbyte = rword[{cur_addr[1:0], 3'b000} +: 8];
    wword = byte_q ? rword : wdata_q;
    if (byte_q) wword[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && req) begin
      state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
      cnt_d = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : cnt_q;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    rdata_d = state_d != RESP ? rdata_q :
              (cur_we || !in_range) ? '0 :
              cur_byte ? {{24{rbyte[7]}}, rbyte} : rword;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk)
    if (state_q == IDLE && req) begin
      we_q <= we;
      byte_q <= byte_op;
      addr_q <= addr;
      wdata_q <= wdata;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (state_q == RESP && we_q && addr_q[31:12] == '0) begin
      mem_q[addr_q[AW+1:2]] <= wword;
`ifdef DM_WRITE_LOG_EN
      $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, wword);
`endif
    end
  end
  assign ready = state_q == RESP;
  assign busy = state_q != IDLE;
  assign rdata = rdata_q;
endmodule

// File: doc/dm_responder.md
# dm_responder

Memory-side responder for the pipelined CPU's data port. The M stage presents load/store requests, and this block answers them over a req/ready handshake after a configurable number of wait states. It owns a 4 KiB word-organised data store and supports word and byte (lb/sb) accesses. It drives `busy` so the hazard unit can freeze the pipeline while a transaction is outstanding.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: wait states inserted between request acceptance and response. Legal range 0–15.
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the store. Must be a power of two, ≤ 1024.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  request valid; held high by the requester until `ready`.
- `we`  in  1  1 = store, 0 = load.
- `byte`  in  1  1 = byte access (lb/sb), 0 = word access.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; byte stores use `wdata[7:0]`.
- `pc`  in  32  PC of the requesting instruction (log only).
- `ready`  out  1  one-cycle pulse; the response is complete.
- `rdata`  out  32  load result; valid while `ready` = 1.
- `busy`  out  1  a transaction is accepted and not yet answered.

## Operation
State machine with three states:
- **IDLE**
  - When `req` = 1, latch `we`, `byte`, `addr`, `wdata` and `pc`.
  - Go to WAIT if `WAIT_CYCLES` > 0; otherwise go to RESP.
- **WAIT**
  - The counter loads `WAIT_CYCLES-1` on entry and decrements each cycle.
  - Go to RESP when the counter is 0.
  - Input changes are ignored; only latched values are used.
- **RESP**
  - Drive `ready` = 1.
  - For a store, perform the write on the clock edge that leaves RESP.
  - Return to IDLE.

Addressing:
- Word index = `addr[11:2]` masked to `DEPTH_WORDS-1`.
- Word accesses ignore `addr[1:0]`.
- Byte lane = `addr[1:0]`; lane 0 is bits 7:0 (little-endian).

Data rules:
- Word load: `rdata` = the stored word.
- Byte load: the selected byte, sign-extended to 32 bits.
- Byte store: writes only the selected lane; the other lanes are unchanged.

Out of range (`addr[31:12]` ≠ 0):
- The block still completes the handshake.
- A store is dropped; a load returns 0.

Outputs:
- `busy` = 1 in WAIT and RESP, 0 in IDLE.
- `rdata` is registered. It holds its value outside RESP, and is 0 after reset or after a store response.

## Timing
- Request sampled in cycle 0 (IDLE, `req` = 1). `ready` is high in cycle `WAIT_CYCLES`+1 and low in every other cycle.
- The earliest next acceptance is cycle `WAIT_CYCLES`+2. The requester must drop `req` or present a new request in the cycle after `ready`; `req` still high there is a new transaction.
- A store is visible to a load accepted after its `ready`. Back-to-back store then load to the same word returns the new data.
- `busy` rises the cycle after acceptance and falls the cycle after `ready`.
- Reset values: state IDLE, counter 0, `ready` 0, `rdata` 0, `busy` 0; all memory words cleared to 0 (synchronous, one cycle).
- Reset during WAIT or RESP abandons the transaction: no write occurs and no `ready` pulse follows.
- `req` during WAIT/RESP is ignored; there is no queueing.

## Configuration
- `DM_WRITE_LOG_EN`
  - Defined: every committed store executes `$display("%d@%h: *%h <= %h", $time, pc, addr_word_aligned, new_word)` on the write edge. The printed word is the full 32-bit word after merging. Dropped out-of-range stores are not printed.
  - Undefined: no display statements are compiled; functional behaviour is identical.

## Test plan
- Word round-trip:
  - Stimulus: `WAIT_CYCLES`=2; store 0x12345678 to addr 0x10, then load 0x10.
  - Required: `ready` in cycle 3 of each request; `rdata` = 0x12345678; `busy` high for exactly 3 cycles per access.
- Byte lanes:
  - Stimulus: store word 0 to 0x20; sb 0x80 to 0x22; load word 0x20; lb 0x22; lb 0x23.
  - Required: word load = 0x00800000; lb 0x22 = 0xFFFFFF80; lb 0x23 = 0x00000000.
- Zero wait:
  - Stimulus: `WAIT_CYCLES`=0; store then load 0x4 held back-to-back.
  - Required: `ready` in the cycle after each acceptance; the load returns the stored value; one idle cycle between transactions.
- Out of range:
  - Stimulus: store 0xDEADBEEF to 0x00001000, then load 0x00001000, then load 0x0.
  - Required: both out-of-range accesses still pulse `ready`; the out-of-range load returns 0; word 0 is unchanged (0).
- Reset mid-transaction:
  - Stimulus: store 0xAAAA5555 to 0x8; assert `reset` during WAIT; then load 0x8.
  - Required: no `ready` pulse for the store; `busy` = 0 the cycle after reset; the load returns 0.
- Log macro:
  - Stimulus: with `DM_WRITE_LOG_EN` defined, sb 0x7F to 0x31 with `pc` = 0x3000.
  - Required: the log line shows `@00003000: *00000030 <= 00007f00`.
  - Without the macro: no output.
